// File: rtl/mul_arb_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing arbiter.
// The package holds the FSM state encoding, the default sizes, and the
// index/tag width helpers that the top and arbiter use.
package mul_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_RETURN   = 3'd5
    } state_t;

    localparam int DEF_DATA_SIZE   = 16;
    localparam int DEF_ID_SIZE     = 8;
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_WDOG_CYCLES = 64;

    // Client index width; a single client still needs one bit of index.
    function automatic int idx_width(input int n_req);
        return (n_req < 2) ? 1 : $clog2(n_req);
    endfunction

    // The multiplier ID is {tag, index}, so the tag gets whatever is left.
    function automatic int tag_width(input int id_size, input int n_req);
        return id_size - idx_width(n_req);
    endfunction

endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// Combinational round-robin picker: returns the first requester strictly
// after the pointer, wrapping. The parent registers the result.
// N_REQ must be a power of two so the wrap is a plain truncation.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan ptr+1, ptr+2, ... ptr+N_REQ (wrapping) and keep the first hit.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = i_ptr + IDX_W'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that lends one shift-and-add multiplier to N_REQ
// clients, one operation in flight at a time.
// Optional feature: define MUL_ARB_WDOG_EN to add a WAIT_RES watchdog that
// raises a sticky wdog_err after WDOG_CYCLES cycles without a result.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter  int DATA_SIZE   = DEF_DATA_SIZE,
    parameter  int ID_SIZE     = DEF_ID_SIZE,
    parameter  int N_REQ       = DEF_N_REQ,
    parameter  int WDOG_CYCLES = DEF_WDOG_CYCLES,
    localparam int OP_W        = DATA_SIZE / 2,
    localparam int IDX_W       = idx_width(N_REQ),
    localparam int TAG_SIZE    = tag_width(ID_SIZE, N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*OP_W-1:0]       req_a,
    input  logic [N_REQ*OP_W-1:0]       req_b,
    input  logic [N_REQ*TAG_SIZE-1:0]   req_tag,
    output logic [N_REQ-1:0]            rsp_valid,
    input  logic [N_REQ-1:0]            rsp_ready,
    output logic [DATA_SIZE:0]          rsp_prod,
    output logic [TAG_SIZE-1:0]         rsp_tag,
    output logic [OP_W-1:0]             mul_a,
    output logic [OP_W-1:0]             mul_b,
    output logic [ID_SIZE-1:0]          mul_id,
    output logic                        mul_valid_data,
    input  logic                        mul_ready_data,
    output logic                        mul_ready_f_res,
    input  logic                        mul_valid_res,
    input  logic [DATA_SIZE+ID_SIZE:0]  mul_result,
    output logic                        mul_written,
    output logic                        wdog_err
);

    state_t                r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [N_REQ-1:0]      r_grant;
    logic [OP_W-1:0]       r_a;
    logic [OP_W-1:0]       r_b;
    logic [TAG_SIZE-1:0]   r_tag;
    logic [DATA_SIZE:0]    r_prod;
    logic                  r_mul_valid;
    logic                  r_mul_written;
    logic [N_REQ-1:0]      r_rsp_valid;

    logic [N_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic [OP_W-1:0]       w_a;
    logic [OP_W-1:0]       w_b;
    logic [TAG_SIZE-1:0]   w_tag;
    logic                  w_rsp_take;
    logic                  w_unused_ok;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_a        = req_a[w_idx*OP_W +: OP_W];
    assign w_b        = req_b[w_idx*OP_W +: OP_W];
    assign w_tag      = req_tag[w_idx*TAG_SIZE +: TAG_SIZE];
    assign w_rsp_take = |(rsp_ready & r_grant);

    // The accept strobe is combinational so the client sees it in the grant cycle.
    assign req_ready       = (r_state == ST_IDLE) ? w_grant : '0;
    assign mul_ready_f_res = (r_state == ST_IDLE);
    assign mul_valid_data  = r_mul_valid;
    assign mul_written     = r_mul_written;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_prod        = r_prod;
    assign rsp_tag         = r_tag;
    assign mul_a           = r_a;
    assign mul_b           = r_b;
    assign mul_id          = {r_tag, r_idx};

    // Only the index half of the returned ID is checked; the tag half is echoed from r_tag.
    assign w_unused_ok = ^{mul_result[DATA_SIZE+ID_SIZE:DATA_SIZE+1+IDX_W], WDOG_CYCLES[0]};

    // Transaction FSM: grant, issue, hold, wait, release, return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= IDX_W'(N_REQ - 1);
            r_idx         <= '0;
            r_grant       <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_tag         <= '0;
            r_prod        <= '0;
            r_mul_valid   <= 1'b0;
            r_mul_written <= 1'b0;
            r_rsp_valid   <= '0;
        end else begin
            // NOTE: state flops use non-blocking assignment so all of them update together at the edge.
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a         <= w_a;
                        r_b         <= w_b;
                        r_tag       <= w_tag;
                        r_idx       <= w_idx;
                        r_grant     <= w_grant;
                        r_ptr       <= w_idx;
                        r_mul_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mul_ready_data) begin
                        r_mul_valid <= 1'b0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Operands stay put for the cycle the multiplier loads them.
                    r_state <= ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (mul_valid_res) begin
                        r_prod        <= mul_result[DATA_SIZE:0];
                        r_mul_written <= 1'b1;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_mul_written <= 1'b0;
                    r_rsp_valid   <= r_grant;
                    r_state       <= ST_RETURN;
                end
                ST_RETURN: begin
                    if (w_rsp_take) begin
                        r_rsp_valid <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUL_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    // Count idle WAIT_RES cycles; flag once the limit is hit and keep the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else if (r_state != ST_WAIT_RES) begin
            r_wdog_cnt <= '0;
        end else if (!mul_valid_res) begin
            if (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
                r_wdog_err <= 1'b1;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign wdog_err = 1'b0;
`endif

    a_id_match: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_WAIT_RES && mul_valid_res) |-> (mul_result[DATA_SIZE+1 +: IDX_W] == r_idx));
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
    a_exclusive:    assert property (@(posedge clk) disable iff (!rst_n) !((|req_ready) && (|rsp_valid)));

endmodule
